ack_bus_rr_scheduler: RTL and testbench

//  Clocked round-robin scheduler for the shared 4-source ACK bus (MEM, SHA, AES, CTRL).

---
 rtl/ack_bus_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_ack_bus_rr_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ack_bus_rr_scheduler.sv
// Round-robin owner scheduler for the shared 4-source ACK bus (MEM, SHA, AES, CTRL).
// Registered one-hot grant held until done, request drop or timeout, then a 2-cycle bus gap.
module ack_bus_rr_scheduler #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       ack_event,
  output logic       timeout_evt,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] timer, timer_nx;
  logic [1:0] last_winner, last_winner_nx;
  logic [3:0] grant_nx;
  logic       grant_valid_nx;
  logic [1:0] grant_id_nx;
  logic       ack_event_nx;
  logic       timeout_evt_nx;
  logic [7:0] timeout_count_nx;
  logic [1:0] winner;
  logic       owner_done, owner_req, at_limit;

  // First set request bit, searching upward from the slot after the last owner.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick_winner = last;
    found       = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      idx = last + d[1:0];
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  always_comb begin
    winner     = pick_winner(req, last_winner);
    owner_done = done[grant_id];
    owner_req  = req[grant_id];
    at_limit   = (timer == TIMER_LIMIT);

    state_nx         = state;
    timer_nx         = timer;
    last_winner_nx   = last_winner;
    grant_nx         = grant;
    grant_valid_nx   = grant_valid;
    grant_id_nx      = grant_id;
    ack_event_nx     = 1'b0;
    timeout_evt_nx   = 1'b0;
    timeout_count_nx = timeout_count;

    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nx       = GRANT;
          grant_nx       = 4'b0001 << winner;
          grant_valid_nx = 1'b1;
          grant_id_nx    = winner;
          ack_event_nx   = 1'b1;
          timer_nx       = 8'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (owner_done || !owner_req || at_limit) begin
          state_nx       = RELEASE;
          grant_nx       = 4'b0000;
          grant_valid_nx = 1'b0;
          last_winner_nx = grant_id;
          // A done or dropped request in the limit cycle is a normal release, not a timeout.
          if (at_limit && owner_req && !owner_done) begin
            timeout_evt_nx = 1'b1;
            if (timeout_count != 8'd255) begin
              timeout_count_nx = timeout_count + 8'd1;
            end else begin
              timeout_count_nx = timeout_count;
            end
          end else begin
            timeout_evt_nx = 1'b0;
          end
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx       = IDLE;
        grant_nx       = 4'b0000;
        grant_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= 8'd0;
      last_winner   <= 2'd3;
      grant         <= 4'b0000;
      grant_valid   <= 1'b0;
      grant_id      <= 2'd0;
      ack_event     <= 1'b0;
      timeout_evt   <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      last_winner   <= last_winner_nx;
      grant         <= grant_nx;
      grant_valid   <= grant_valid_nx;
      grant_id      <= grant_id_nx;
      ack_event     <= ack_event_nx;
      timeout_evt   <= timeout_evt_nx;
      timeout_count <= timeout_count_nx;
    end
  end

endmodule

// File: tb/tb_ack_bus_rr_scheduler.sv
// Self-checking bench for ack_bus_rr_scheduler: directed scenarios plus random traffic
// against an ownership-level reference model (owner, cycles held, gap phase, counters).
module tb_ack_bus_rr_scheduler;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       ack_event;
  logic       timeout_evt;
  logic [7:0] timeout_count;

  int vecs;
  int errs;

  // reference model state
  int m_owner;
  int m_held;
  int m_rel;
  int m_last;
  int m_id;
  int m_cnt;
  int m_ack;
  int m_to;
  int m_timeouts;

  ack_bus_rr_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .ack_event(ack_event), .timeout_evt(timeout_evt), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] obs_vec();
    return {grant, grant_valid, grant_id, ack_event, timeout_evt, timeout_count};
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, (m_owner >= 0), 2'(m_id), 1'(m_ack), 1'(m_to), 8'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_rel = 0; m_last = 3; m_id = 0;
    m_cnt = 0; m_ack = 0; m_to = 0;
  endtask

  task automatic model_step();
    int w;
    m_ack = 0;
    m_to  = 0;
    if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner] || m_held == TIMEOUT) begin
        m_to = (m_held == TIMEOUT && !done[m_owner] && req[m_owner]) ? 1 : 0;
        if (m_to == 1) begin
          m_timeouts++;
          if (m_cnt < 255) m_cnt++;
        end
        m_last  = m_owner;
        m_owner = -1;
        m_rel   = 1;
      end else begin
        m_held++;
      end
    end else if (m_rel == 1) begin
      m_rel = 0;
    end else if (req != 4'b0000) begin
      for (int d = 1; d <= 4; d++) begin
        w = (m_last + d) % 4;
        if (m_owner < 0 && req[w]) begin
          m_owner = w; m_id = w; m_held = 1; m_ack = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; done = 4'b0000;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (obs_vec() !== 17'd0) begin
      $display("FAIL reset_state: got %h want %h", obs_vec(), 17'd0); errs++;
    end
    vecs++;
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL t1_first_grant cyc %0d: got %h want %h", i, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
    end
  endtask

  task automatic test_rotation();
    int ids[$];
    int low_run;
    int seen;
    do_reset();
    req = 4'b1111;
    low_run = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL t2_rotation cyc %0d: got %h want %h", i, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
      if (ack_event) begin
        ids.push_back(int'(grant_id));
        if (seen > 0) begin
          if (low_run !== 2) begin
            $display("FAIL t2_gap: got %0d low cycles want 2", low_run); errs++;
          end
          vecs++;
        end
        seen++;
      end
      low_run = (grant == 4'b0000) ? low_run + 1 : 0;
      done = (m_owner >= 0 && m_held == 2) ? 4'(1 << m_owner) : 4'b0000;
    end
    done = 4'b0000;
    if (ids.size() !== 5) begin
      $display("FAIL t2_grant_count: got %0d want 5", ids.size()); errs++;
    end
    vecs++;
    for (int k = 0; k < 5 && k < ids.size(); k++) begin
      if (ids[k] !== (k % 4)) begin
        $display("FAIL t2_owner_order[%0d]: got %0d want %0d", k, ids[k], k % 4); errs++;
      end
      vecs++;
    end
  endtask

  task automatic test_timeout();
    int held;
    int fired;
    do_reset();
    req = 4'b0100;
    held = 0; fired = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL t3_timeout cyc %0d: got %h want %h", i, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
      if (fired == 0 && grant == 4'b0100) held++;
      if (fired == 0 && timeout_evt) begin
        fired = 1;
        if (held !== TIMEOUT || timeout_count !== 8'd1) begin
          $display("FAIL t3_timeout_len: got held %0d count %0d want %0d and 1", held, timeout_count, TIMEOUT);
          errs++;
        end
        vecs++;
      end
    end
    if (fired == 0) begin
      $display("FAIL t3_no_timeout: got no timeout_evt want one within 40 cycles"); errs++;
      vecs++;
    end
  endtask

  task automatic test_done_wins();
    int cnt0;
    int budget;
    do_reset();
    req = 4'b0100;
    cnt0 = 0;
    budget = 0;
    while (!(m_owner == 2 && m_held == 1) && budget < 10) begin
      tick(); budget++;
    end
    for (int i = 0; i < 24; i++) begin
      done = (m_owner == 2 && m_held == TIMEOUT) ? 4'b0100 : 4'b0000;
      tick();
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL t4_done_wins cyc %0d: got %h want %h", i, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
      if (timeout_evt !== 1'b0 || timeout_count !== 8'(cnt0)) begin
        $display("FAIL t4_no_timeout cyc %0d: got evt %b count %0d want 0 and %0d", i, timeout_evt, timeout_count, cnt0);
        errs++;
      end
      vecs++;
    end
    done = 4'b0000;
  endtask

  task automatic test_async_reset();
    int budget;
    do_reset();
    req = 4'b1111;
    budget = 0;
    while (!(m_owner == 1 && m_held == 1) && budget < 30) begin
      done = (m_owner >= 0 && m_held == 2) ? 4'(1 << m_owner) : 4'b0000;
      tick(); budget++;
    end
    done = 4'b0000;
    if (grant !== 4'b0010) begin
      $display("FAIL t5_sha_owner: got %b want 0010", grant); errs++;
    end
    vecs++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (obs_vec() !== 17'd0) begin
      $display("FAIL t5_async_drop: got %h want %h", obs_vec(), 17'd0); errs++;
    end
    vecs++;
    tick();
    rst_n = 1'b1;
    tick();
    if (grant !== 4'b0001 || ack_event !== 1'b1 || obs_vec() !== exp_vec()) begin
      $display("FAIL t5_restart_mem: got %h want %h", obs_vec(), exp_vec()); errs++;
    end
    vecs++;
  endtask

  task automatic test_saturation();
    int budget;
    do_reset();
    req = 4'b0100;
    m_timeouts = 0;
    budget = 0;
    while (m_timeouts < 260 && budget < 6000) begin
      done = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      tick(); budget++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL t6_saturation cyc %0d: got %h want %h", budget, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
    end
    done = 4'b0000;
    if (m_timeouts < 260) begin
      $display("FAIL t6_budget: got %0d timeouts want 260", m_timeouts); errs++;
      vecs++;
    end
    if (timeout_count !== 8'd255) begin
      $display("FAIL t6_count_sat: got %0d want 255", timeout_count); errs++;
    end
    vecs++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 3) != 0) req = req | ((m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000);
      tick();
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec()); errs++;
      end
      vecs++;
    end
  endtask

  initial begin
    vecs = 0; errs = 0; m_timeouts = 0;
    rst_n = 1'b0; req = 4'b0000; done = 4'b0000;
    model_reset();
    test_reset();
    test_rotation();
    test_timeout();
    test_done_wins();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
